l2_req_arbiter: RTL and testbench
=================================

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 The clock and reset SHALL be as follows: one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  the single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 ic_req  in  1  L1 icache request; held high by requester until ic_done.
REQ-005 ic_addr  in  32  icache miss address.
REQ-006 dc_req  in  1  L1 dcache request; held high by requester until dc_done.
REQ-007 dc_addr  in  32  dcache miss address.
REQ-008 dc_rw  in  1  dcache access direction (READ/WRITE, team encoding).
REQ-009 l2_busy  in  1  L2 controller has accepted a request and is working.
REQ-010 l2_complete  in  1  L2 transaction finished (data written back to L1).
REQ-011 l2_req  out  1  request to L2 controller.
REQ-012 l2_addr  out  32  registered address of the granted requester.
REQ-013 l2_rw  out  1  registered direction; READ for icache grants.
REQ-014 ic_gnt, dc_gnt  out  1 each  one-hot grant, high from grant until done cycle inclusive.
REQ-015 ic_done, dc_done  out  1 each  single-cycle completion pulse to the owning requester.
REQ-016 arb_timeout  out  1  sticky error: WAIT exceeded 255 cycles.

Function
REQ-017 States SHALL be ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE.
REQ-018 ARB_IDLE: if any req high, SHALL pick owner, latch addr/rw into l2_addr/l2_rw, set grant, go ARB_ISSUE next cycle; else stay.
REQ-019 Pick: single requester wins; both high -> requester not served last (round-robin, last_owner register).
REQ-020 ARB_ISSUE: l2_req SHALL be high; on l2_busy=1 -> ARB_WAIT (l2_req low from that next cycle).
REQ-021 ARB_WAIT: on l2_complete=1 -> ARB_DONE; l2_complete outside ARB_WAIT SHALL be ignored.
REQ-022 ARB_DONE: owner's done SHALL pulse exactly one cycle, last_owner <= owner, grant cleared, -> ARB_IDLE.
REQ-023 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, ISSUE, WAIT, DONE); back-to-back requests from other requester granted in the IDLE cycle following DONE.
REQ-024 l2_addr/l2_rw SHALL remain stable from ISSUE entry through DONE regardless of requester input changes.
REQ-025 Requester dropping req after grant SHALL NOT abort; transaction completes, done still pulses.
REQ-026 Watchdog: 8-bit counter cleared on WAIT entry, increments each WAIT cycle, saturates at 255; reaching 255 SHALL set arb_timeout (cleared only by reset); FSM stays in WAIT.
REQ-027 A request arriving while non-IDLE SHALL be held off (no grant) until IDLE; no request lost.

Reset
REQ-028 On rst=0 at posedge: state ARB_IDLE, l2_req 0, l2_addr 0, l2_rw READ, grants 0, dones 0, arb_timeout 0, counter 0, last_owner = dcache (icache wins first tie).
REQ-029 Reset mid-transaction SHALL abandon it immediately with no done pulse.

Structure
REQ-030 State codes, owner IDs (OWN_IC, OWN_DC) and WATCHDOG_MAX=255 SHALL live in shared header l2_arb.h, alongside stddef.h READ/WRITE/ENABLE/DISABLE.
REQ-031 One sub-module SHALL be used: l2_arb_rr (2-way round-robin pick, last_owner in, owner/valid out); everything else in l2_req_arbiter.

Verification
REQ-032 ic_req=1, ic_addr=0x0000_1040, l2_busy 1 cycle after l2_req, l2_complete 5 cycles later -> l2_addr=0x0000_1040, l2_rw=READ, ic_done one pulse, dc_gnt never high.
REQ-033 ic_req and dc_req rise same cycle after reset -> icache granted first, dcache (dc_addr=0x8000_0200, dc_rw=WRITE) granted in IDLE after ic_done; l2_rw=WRITE.
REQ-034 Both held continuously for 4 transactions -> grants alternate IC,DC,IC,DC.
REQ-035 dc_addr changes 0x100->0x200 during WAIT -> l2_addr stays 0x100 until dc_done.
REQ-036 l2_complete never asserted -> arb_timeout=1 exactly 255 WAIT cycles after entry; stays in WAIT; rst=0 clears all outputs.
REQ-037 rst=0 during ARB_WAIT of ic transaction -> next cycle all outputs reset values, no ic_done pulse.

Source files
------------

// File: rtl/l2_req_arbiter_pkg.sv
// l2_req_arbiter_pkg: shared state codes, owner IDs and encodings for the L2 request arbiter
package l2_req_arbiter_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
   typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;
   localparam logic READ = 1'b0;
   localparam logic WRITE = 1'b1;
   localparam logic ENABLE = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic [7:0] WATCHDOG_MAX = 8'd255;
endpackage

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if: L1 requester and L2 controller handshake bundle around the arbiter
interface l2_req_arbiter_if;
   logic ic_req;
   logic [31:0] ic_addr;
   logic dc_req;
   logic [31:0] dc_addr;
   logic dc_rw;
   logic l2_busy;
   logic l2_complete;
   logic l2_req;
   logic [31:0] l2_addr;
   logic l2_rw;
   logic ic_gnt;
   logic dc_gnt;
   logic ic_done;
   logic dc_done;
   logic arb_timeout;
   modport master (
      output ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_complete,
      input l2_req, l2_addr, l2_rw, ic_gnt, dc_gnt, ic_done, dc_done, arb_timeout
   );
   modport slave (
      input ic_req, ic_addr, dc_req, dc_addr, dc_rw, l2_busy, l2_complete,
      output l2_req, l2_addr, l2_rw, ic_gnt, dc_gnt, ic_done, dc_done, arb_timeout
   );
endinterface

// File: rtl/l2_arb_rr.sv
// l2_arb_rr: 2-way round-robin pick; on a tie the requester not served last wins
module l2_arb_rr import l2_req_arbiter_pkg::*; (
   input logic ic_req,
   input logic dc_req,
   input owner_t last_owner,
   output owner_t owner,
   output logic valid
);
   assign valid = ic_req | dc_req;
   assign owner = (ic_req & dc_req) ? (last_owner == OWN_IC ? OWN_DC : OWN_IC) : (dc_req ? OWN_DC : OWN_IC);
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: grants one L1 cache at a time to the L2 controller, with a WAIT watchdog
module l2_req_arbiter import l2_req_arbiter_pkg::*; (
   input logic clk,
   input logic rst,
   l2_req_arbiter_if.slave bus
);
   arb_state_t state;
   owner_t owner, last_owner, pick;
   logic pick_valid;
   logic [7:0] wd_cnt;
   l2_arb_rr u_rr (
      .ic_req(bus.ic_req),
      .dc_req(bus.dc_req),
      .last_owner(last_owner),
      .owner(pick),
      .valid(pick_valid)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ARB_IDLE;
         owner <= OWN_IC;
         last_owner <= OWN_DC;
         wd_cnt <= '0;
         bus.l2_req <= DISABLE;
         bus.l2_addr <= '0;
         bus.l2_rw <= READ;
         bus.ic_gnt <= DISABLE;
         bus.dc_gnt <= DISABLE;
         bus.ic_done <= DISABLE;
         bus.dc_done <= DISABLE;
         bus.arb_timeout <= DISABLE;
      end else begin
         case (state)
            ARB_IDLE: if (pick_valid) begin
               state <= ARB_ISSUE;
               owner <= pick;
               bus.l2_req <= ENABLE;
               bus.l2_addr <= pick == OWN_DC ? bus.dc_addr : bus.ic_addr;
               bus.l2_rw <= pick == OWN_DC ? bus.dc_rw : READ;
               bus.ic_gnt <= pick == OWN_IC;
               bus.dc_gnt <= pick == OWN_DC;
            end
            ARB_ISSUE: if (bus.l2_busy) begin
               state <= ARB_WAIT;
               bus.l2_req <= DISABLE;
               wd_cnt <= '0;
            end
            ARB_WAIT: if (bus.l2_complete) begin
               state <= ARB_DONE;
               bus.ic_done <= owner == OWN_IC;
               bus.dc_done <= owner == OWN_DC;
            end else begin
               // watchdog flags on the edge where the count reaches its ceiling; the FSM keeps waiting
               if (wd_cnt != WATCHDOG_MAX) wd_cnt <= wd_cnt + 8'd1;
               if (wd_cnt == WATCHDOG_MAX - 8'd1) bus.arb_timeout <= ENABLE;
            end
            ARB_DONE: begin
               state <= ARB_IDLE;
               last_owner <= owner;
               bus.ic_gnt <= DISABLE;
               bus.dc_gnt <= DISABLE;
               bus.ic_done <= DISABLE;
               bus.dc_done <= DISABLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: transaction-level model checked every cycle plus directed literal checks
module tb_l2_req_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   l2_req_arbiter_if bus ();
   l2_req_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0, errors = 0;
   int ic_done_n = 0, dc_done_n = 0;
   bit dc_gnt_seen = 0, pg_ic = 0, pg_dc = 0;
   int glog[$];
   bit l2_auto = 1;
   int rsp = 0, cnt = 0;
   bit mv = 0;
   int m_owner = -1, m_last = 1, m_wait = 0;
   bit m_acc = 0, m_fin = 0, m_to = 0;
   logic [31:0] m_addr = '0;
   logic m_rw = 1'b0;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   function automatic logic [38:0] act_vec();
      return {bus.l2_req, bus.l2_addr, bus.l2_rw, bus.ic_gnt, bus.dc_gnt, bus.ic_done, bus.dc_done, bus.arb_timeout};
   endfunction
   function automatic logic [38:0] exp_vec();
      return {m_owner >= 0 && !m_acc, m_addr, m_rw, m_owner == 0, m_owner == 1,
              m_fin && m_owner == 0, m_fin && m_owner == 1, m_to};
   endfunction
   // model: one owner at a time, accepted by l2_busy, finished by l2_complete, released the cycle after
   always @(posedge clk) begin
      if (!rst) begin
         m_owner = -1; m_last = 1; m_acc = 0; m_fin = 0; m_to = 0; m_wait = 0; m_addr = '0; m_rw = 1'b0; mv = 1;
      end else if (m_owner < 0) begin
         if (bus.ic_req || bus.dc_req) begin
            m_owner = (bus.ic_req && bus.dc_req) ? 1 - m_last : (bus.dc_req ? 1 : 0);
            m_addr = (m_owner == 1) ? bus.dc_addr : bus.ic_addr;
            m_rw = (m_owner == 1) ? bus.dc_rw : 1'b0;
            m_acc = 0; m_fin = 0;
         end
      end else if (m_fin) begin
         m_last = m_owner; m_owner = -1; m_fin = 0;
      end else if (!m_acc) begin
         if (bus.l2_busy) begin m_acc = 1; m_wait = 0; end
      end else if (bus.l2_complete) m_fin = 1;
      else begin
         if (m_wait < 255) m_wait++;
         if (m_wait == 255) m_to = 1;
      end
   end
   always @(negedge clk) if (mv) begin
      chk("cycle", act_vec(), exp_vec());
      if (bus.ic_done) ic_done_n++;
      if (bus.dc_done) dc_done_n++;
      if (bus.dc_gnt) dc_gnt_seen = 1;
      if (bus.ic_gnt && !pg_ic) glog.push_back(0);
      if (bus.dc_gnt && !pg_dc) glog.push_back(1);
      pg_ic = bus.ic_gnt;
      pg_dc = bus.dc_gnt;
   end
   // L2 responder: busy one cycle after l2_req is seen, complete 5 cycles after busy
   task automatic respond();
      if (l2_auto) begin
         bus.l2_busy = 1'b0;
         bus.l2_complete = 1'b0;
         if (!rst) rsp = 0;
         else if (rsp == 0) rsp = bus.l2_req ? 1 : 0;
         else if (rsp == 1) begin bus.l2_busy = 1'b1; rsp = 2; cnt = 0; end
         else begin
            cnt++;
            if (cnt == 5) begin bus.l2_complete = 1'b1; rsp = 0; end
         end
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2 respond();
         #1;
      end
   endtask
   task automatic wait_for(input string n, input int sel, input int maxc);
      int i;
      for (i = 0; i < maxc; i++) begin
         if ((sel == 0 && bus.ic_done) || (sel == 1 && bus.dc_done) || (sel == 2 && bus.l2_req) ||
             (sel == 3 && bus.dc_gnt) || (sel == 4 && !bus.ic_gnt && !bus.dc_gnt)) break;
         tick();
      end
      if (i == maxc) begin
         checks++;
         errors++;
         $display("FAIL wait_%s: no event within %0d cycles", n, maxc);
      end
   endtask
   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick();
   endtask
   int base;
   logic [3:0] ord;
   initial begin
      bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_addr = '0; bus.dc_rw = 0;
      bus.l2_busy = 0; bus.l2_complete = 0;
      tick(3);
      chk("reset_outputs", 64'(act_vec()), 64'h0);
      chk("model_reset", 64'(exp_vec()), 64'h0);
      rst = 1'b1;
      tick();
      // single icache read
      dc_gnt_seen = 0;
      base = ic_done_n;
      bus.ic_addr = 32'h0000_1040;
      bus.ic_req = 1;
      wait_for("ic_done1", 0, 30);
      chk("t1_addr", 64'(bus.l2_addr), 64'h0000_1040);
      chk("t1_rw", 64'(bus.l2_rw), 64'h0);
      chk("model_t1_addr", 64'(m_addr), 64'h0000_1040);
      bus.ic_req = 0;
      tick(3);
      chk("t1_done_pulses", 64'(ic_done_n - base), 64'd1);
      chk("t1_no_dc_gnt", 64'(dc_gnt_seen), 64'd0);
      // simultaneous requests after reset: icache first, dcache right after
      do_reset();
      base = glog.size();
      bus.ic_addr = 32'h0000_2000;
      bus.dc_addr = 32'h8000_0200;
      bus.dc_rw = 1;
      bus.ic_req = 1;
      bus.dc_req = 1;
      wait_for("ic_done2", 0, 30);
      bus.ic_req = 0;
      tick();
      chk("t2_idle_gap", 64'({bus.ic_gnt, bus.dc_gnt}), 64'h0);
      tick();
      chk("t2_dc_gnt", 64'({bus.ic_gnt, bus.dc_gnt}), 64'h1);
      chk("t2_addr", 64'(bus.l2_addr), 64'h8000_0200);
      chk("t2_rw", 64'(bus.l2_rw), 64'h1);
      wait_for("dc_done2", 1, 30);
      bus.dc_req = 0;
      tick(2);
      chk("t2_order", 64'(glog.size() - base == 2 ? {glog[base][0], glog[base + 1][0]} : 2'b11), 64'b01);
      // both held: alternating grants
      do_reset();
      base = glog.size();
      bus.dc_addr = 32'h0000_3000;
      bus.dc_rw = 0;
      bus.ic_req = 1;
      bus.dc_req = 1;
      for (int i = 0; i < 200 && glog.size() < base + 4; i++) tick();
      ord = 4'b1111;
      if (glog.size() >= base + 4) ord = {glog[base][0], glog[base + 1][0], glog[base + 2][0], glog[base + 3][0]};
      chk("t3_alternate", 64'(ord), 64'b0101);
      base = dc_done_n;
      bus.ic_req = 0;
      bus.dc_req = 0;
      wait_for("t3_idle", 4, 40);
      chk("t3_drop_still_done", 64'(dc_done_n - base), 64'd1);
      tick(2);
      // address change during WAIT is not seen on l2_addr
      bus.dc_addr = 32'h0000_0100;
      bus.dc_rw = 0;
      bus.dc_req = 1;
      wait_for("t4_gnt", 3, 20);
      tick(3);
      bus.dc_addr = 32'h0000_0200;
      wait_for("t4_done", 1, 30);
      chk("t4_addr_stable", 64'(bus.l2_addr), 64'h0000_0100);
      bus.dc_req = 0;
      tick(3);
      // watchdog: l2_complete never comes
      l2_auto = 0;
      bus.l2_busy = 0;
      bus.l2_complete = 0;
      bus.ic_addr = 32'h0000_5000;
      bus.ic_req = 1;
      wait_for("t5_req", 2, 20);
      bus.l2_busy = 1;
      tick();
      bus.l2_busy = 0;
      tick(254);
      chk("t5_no_timeout_yet", 64'(bus.arb_timeout), 64'h0);
      tick();
      chk("t5_timeout", 64'(bus.arb_timeout), 64'h1);
      tick(5);
      chk("t5_still_wait", 64'({bus.l2_req, bus.ic_gnt, bus.ic_done, bus.arb_timeout}), 64'b0101);
      rst = 0;
      tick();
      chk("t5_reset_clears", 64'(act_vec()), 64'h0);
      bus.ic_req = 0;
      tick();
      // reset during WAIT abandons the transaction; early l2_complete is ignored
      rst = 1;
      tick();
      bus.ic_addr = 32'h0000_4000;
      bus.ic_req = 1;
      wait_for("t6_req", 2, 20);
      bus.l2_complete = 1;
      tick();
      bus.l2_complete = 0;
      tick();
      chk("t6_complete_ignored", 64'({bus.l2_req, bus.ic_done}), 64'b10);
      bus.l2_busy = 1;
      tick();
      bus.l2_busy = 0;
      tick(2);
      base = ic_done_n;
      rst = 0;
      tick();
      chk("t6_reset_outputs", 64'(act_vec()), 64'h0);
      bus.ic_req = 0;
      tick(3);
      chk("t6_no_done", 64'(ic_done_n - base), 64'd0);
      rst = 1;
      l2_auto = 1;
      rsp = 0;
      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
